// File: rtl/cmd_pkg.sv
// Shared definitions for the host command path: assembler state encoding,
// command width and the opcode values decoded by the command processor.
package cmd_pkg;

  localparam int CMD_W = 24;

  localparam logic [3:0] DUMP_CHN = 4'h1;
  localparam logic [3:0] CFG_GAIN = 4'h2;
  localparam logic [3:0] SET_TRIG = 4'h3;
  localparam logic [3:0] WRT_EEP  = 4'h8;
  localparam logic [3:0] RD_EEP   = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    GOT2  = 2'd2,
    READY = 2'd3
  } asm_state_e;

endpackage

// File: rtl/cmd_assembler.sv
// Assembles three UART bytes into a 24-bit host command held until acknowledged.
// Optional inter-byte timeout is built when CMD_ASM_TIMEOUT_EN is defined.
module cmd_assembler
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TMO_W       = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  input  logic             clr_cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic             overrun,
  input  logic             clr_overrun
);

  // Catch a counter too narrow to ever reach the timeout value.
  if ((TMO_W < 1) || (TMO_W < 32 && (64'd1 << TMO_W) <= 64'(TIMEOUT_CYC)))
    $error("cmd_assembler: TMO_W too small for TIMEOUT_CYC");

  asm_state_e       state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             overrun_q, overrun_d;

`ifdef CMD_ASM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      IDLE: if (rx_rdy) begin
        cmd_d[23:16] = rx_data;
        state_d      = GOT1;
      end
      GOT1: if (rx_rdy) begin
        cmd_d[15:8] = rx_data;
        state_d     = GOT2;
      end
      GOT2: if (rx_rdy) begin
        cmd_d[7:0] = rx_data;
        cmd_rdy_d  = 1'b1;
        state_d    = READY;
      end
      READY: begin
        // An ack in the same cycle as a byte frees the slot, so the byte starts a new command.
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          if (rx_rdy) begin
            cmd_d[23:16] = rx_data;
            state_d      = GOT1;
          end else begin
            state_d = IDLE;
          end
        end else if (rx_rdy) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CMD_ASM_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == GOT1 || state_q == GOT2) && !rx_rdy) begin
      if (tmo_q == TMO_LAST) state_d = IDLE;
      else                   tmo_d   = tmo_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef CMD_ASM_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
`ifdef CMD_ASM_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign overrun = overrun_q;

endmodule
